// File: rtl/dsm_serial_loader.sv
// dsm_serial_loader: 3-wire (sclk/sdata/en) serial programming master for the DSM shift register.
// Ports: clk, rst_n (sync, active-low); word_in/start accept a word when ready;
//        done pulses one cycle at frame end; sclk/sdata/en drive the receiver (MSB first).
// Optional macro DSM_SERIAL_LOADER_AUTO_EN: self-start when word_in differs from the last sent word.
module dsm_serial_loader #(
  parameter int WORD_W   = 9,
  parameter int HALF_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              start,
  output logic              ready,
  output logic              done,
  output logic              sclk,
  output logic              sdata,
  output logic              en
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  localparam int PW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;
  localparam int BW = WORD_W > 1 ? $clog2(WORD_W) : 1;
  logic [1:0] state, state_n;
  logic [PW-1:0] ph;
  logic [BW-1:0] bits;
  logic [WORD_W-1:0] shadow, shadow_n;
  logic ph_end, last_bit, go, accept;
  assign ph_end   = ph == PW'(HALF_DIV - 1);
  assign last_bit = bits == BW'(WORD_W - 1);
  assign accept   = ready & go;
`ifdef DSM_SERIAL_LOADER_AUTO_EN
  logic [WORD_W-1:0] copy;
  logic never_sent;
  assign go = start | never_sent | (word_in != copy);
  always_ff @(posedge clk)
    if (!rst_n) begin
      copy       <= '0;
      never_sent <= 1'b1;
    end else if (accept) begin
      copy       <= word_in;
      never_sent <= 1'b0;
    end
`else
  assign go = start;
`endif
  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    unique case (state)
      IDLE: if (accept) begin
        state_n  = LOW;
        shadow_n = word_in;
      end
      LOW:  if (ph_end) state_n = HIGH;
      HIGH: if (ph_end) begin
        state_n  = last_bit ? HOLD : LOW;
        shadow_n = last_bit ? shadow : shadow << 1;
      end
      default: if (ph_end) state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next-state decode so they change only on clk edges.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state  <= IDLE;
      ph     <= '0;
      bits   <= '0;
      shadow <= '0;
      ready  <= 1'b1;
      done   <= 1'b0;
      sclk   <= 1'b0;
      sdata  <= 1'b0;
      en     <= 1'b0;
    end else begin
      state  <= state_n;
      ph     <= (state_n != state || state == IDLE) ? '0 : ph + 1'b1;
      bits   <= state == IDLE ? '0 : (state == HIGH && state_n == LOW) ? bits + 1'b1 : bits;
      shadow <= shadow_n;
      ready  <= state_n == IDLE;
      done   <= state == HOLD && state_n == IDLE;
      sclk   <= state_n == HIGH;
      en     <= state_n != IDLE;
      sdata  <= state_n != IDLE && shadow_n[WORD_W-1];
    end
endmodule

// File: tb/tb_dsm_serial_loader.sv
// tb_dsm_serial_loader: self-checking bench for dsm_serial_loader (instance 0 HALF_DIV=2, instance 1 HALF_DIV=1).
module tb_dsm_serial_loader;
  localparam int W = 9;
  int hd [2] = '{2, 1};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n [2];
  logic start [2];
  logic [W-1:0] word [2];
  logic ready [2], done [2], sclk [2], sdata [2], en [2];
  dsm_serial_loader #(.WORD_W(W), .HALF_DIV(2)) u0 (
    .clk(clk), .rst_n(rst_n[0]), .word_in(word[0]), .start(start[0]),
    .ready(ready[0]), .done(done[0]), .sclk(sclk[0]), .sdata(sdata[0]), .en(en[0]));
  dsm_serial_loader #(.WORD_W(W), .HALF_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .word_in(word[1]), .start(start[1]),
    .ready(ready[1]), .done(done[1]), .sclk(sclk[1]), .sdata(sdata[1]), .en(en[1]));
  int checks = 0;
  int failures = 0;
  // Receiver model: samples sdata on sclk rising edges while en is high, and measures framing.
  logic pe [2] = '{1'b0, 1'b0};
  logic ps [2] = '{1'b0, 1'b0};
  logic psd [2] = '{1'b0, 1'b0};
  logic [W-1:0] rx [2], last_rx [2], prev_rx [2];
  int edges [2] = '{0, 0};
  int last_edges [2] = '{0, 0};
  int len [2] = '{0, 0};
  int last_len [2] = '{0, 0};
  int gap [2] = '{0, 0};
  int gap_last [2] = '{0, 0};
  int falls [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int done_bad [2] = '{0, 0};
  int proto [2] = '{0, 0};
  int stall [2] = '{0, 0};
  always @(negedge clk)
    for (int i = 0; i < 2; i++) begin
      if (!pe[i] && en[i]) begin
        rx[i] = '0;
        edges[i] = 0;
        len[i] = 0;
        gap_last[i] = gap[i];
      end
      if (pe[i] && !en[i]) begin
        prev_rx[i] = last_rx[i];
        last_rx[i] = rx[i];
        last_edges[i] = edges[i];
        last_len[i] = len[i];
        gap[i] = 0;
        falls[i]++;
      end
      if (en[i]) len[i]++;
      else gap[i]++;
      if (en[i] && sclk[i] && !ps[i]) begin
        rx[i] = {rx[i][W-2:0], sdata[i]};
        edges[i]++;
      end
      if (en[i] && ps[i] && sclk[i] && sdata[i] !== psd[i]) proto[i]++;
      if (i == 1 && en[i] && pe[i] && sclk[i] === ps[i]) stall[i]++;
      if (done[i]) begin
        dones[i]++;
        if (en[i] || !pe[i]) done_bad[i]++;
      end
      pe[i] = en[i];
      ps[i] = sclk[i];
      psd[i] = sdata[i];
    end
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_falls(int i, int t);
    int n = 0;
    while (falls[i] < t && n < 2000) begin
      tick;
      n++;
    end
    chk("frame_timeout", int'(falls[i] >= t), 1);
  endtask
  task automatic accept(int i, logic [W-1:0] w);
    int n = 0;
    while (!ready[i] && n < 200) begin
      tick;
      n++;
    end
    chk("ready_wait", int'(ready[i]), 1);
    word[i] = w;
    start[i] = 1'b1;
    tick;
    start[i] = 1'b0;
    chk("en_after_accept", int'(en[i]), 1);
    chk("ready_busy", int'(ready[i]), 0);
  endtask
  task automatic finish(int i, int f0, int d0, logic [W-1:0] w);
    wait_falls(i, f0 + 1);
    chk("rx_word", int'(last_rx[i]), int'(w));
    chk("rise_edges", last_edges[i], W);
    chk("en_len", last_len[i], (2 * W + 1) * hd[i]);
    chk("done_count", dones[i], d0 + 1);
  endtask
  task automatic send(int i, logic [W-1:0] w);
    int f0 = falls[i];
    int d0 = dones[i];
    accept(i, w);
    finish(i, f0, d0, w);
  endtask
  initial begin
    int f0, d0, n;
    logic [W-1:0] w;
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      word[i] = '0;
    end
    repeat (3) tick;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", int'(ready[i]), 1);
      chk("rst_done", int'(done[i]), 0);
      chk("rst_sclk", int'(sclk[i]), 0);
      chk("rst_sdata", int'(sdata[i]), 0);
      chk("rst_en", int'(en[i]), 0);
      rst_n[i] = 1'b1;
    end
`ifdef DSM_SERIAL_LOADER_AUTO_EN
    for (int i = 0; i < 2; i++) begin
      wait_falls(i, 1);
      chk("auto_first_word", int'(last_rx[i]), 0);
      word[i] = 9'h07A;
    end
    for (int i = 0; i < 2; i++) begin
      wait_falls(i, 2);
      chk("auto_change_word", int'(last_rx[i]), 9'h07A);
    end
    repeat (150) tick;
    for (int i = 0; i < 2; i++) chk("auto_no_repeat", falls[i], 2);
`else
    repeat (20) tick;
    chk("no_self_start", falls[0] + falls[1], 0);
    send(0, 9'h1A5);
    f0 = falls[0];
    d0 = dones[0];
    accept(0, 9'h1A5);
    repeat (17) tick;
    word[0] = 9'h0FF;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    finish(0, f0, d0, 9'h1A5);
    repeat (5) tick;
    chk("busy_start_not_queued", int'(en[0]), 0);
    send(0, 9'h0FF);
    send(1, 9'h155);
    f0 = falls[0];
    d0 = dones[0];
    accept(0, 9'h0AA);
    n = 0;
    while (!(edges[0] == 5 && sclk[0]) && n < 200) begin
      tick;
      n++;
    end
    chk("reach_5th_high", edges[0], 5);
    rst_n[0] = 1'b0;
    tick;
    chk("midrst_en", int'(en[0]), 0);
    chk("midrst_sclk", int'(sclk[0]), 0);
    chk("midrst_sdata", int'(sdata[0]), 0);
    chk("midrst_ready", int'(ready[0]), 1);
    chk("midrst_done", int'(done[0]), 0);
    rst_n[0] = 1'b1;
    repeat (10) tick;
    chk("midrst_no_done", dones[0], d0);
    send(0, 9'h003);
    f0 = falls[0];
    word[0] = 9'h001;
    start[0] = 1'b1;
    tick;
    word[0] = 9'h100;
    wait_falls(0, f0 + 1);
    tick;
    start[0] = 1'b0;
    wait_falls(0, f0 + 2);
    chk("b2b_first", int'(prev_rx[0]), 9'h001);
    chk("b2b_second", int'(last_rx[0]), 9'h100);
    chk("b2b_gap", gap_last[0], 1);
    for (int k = 0; k < 6; k++) begin
      int i = k % 2;
      w = W'($urandom);
      f0 = falls[i];
      d0 = dones[i];
      accept(i, w);
      repeat ($urandom_range(1, 15)) begin
        word[i] = W'($urandom);
        start[i] = 1'($urandom);
        tick;
      end
      start[i] = 1'b0;
      finish(i, f0, d0, w);
    end
    chk("half_div1_toggle", stall[1], 0);
`endif
    for (int i = 0; i < 2; i++) begin
      chk("sdata_stable_high", proto[i], 0);
      chk("done_at_en_fall", done_bad[i], 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsm_serial_loader.md
# dsm_serial_loader

Serial programming master that transmits a parallel fractional word over the 3-wire `sclk`/`sdata`/`en` interface into the DSM's serial-to-parallel shift register. It sits in the digital control domain between the configuration source (register file or test controller) and the fractional-N divider's shift register. It generates a slow serial clock from the system clock and frames each word with `en`.

## Interface

Parameters:
- `WORD_W`, default 9: transmitted word width, equal to the receiver shift-register width.
- `HALF_DIV`, default 4: `sclk` half-period in `clk` cycles. Legal values are ≥1.

Ports:
- `clk`, input, 1 bit: system clock. This is the block's only clock.
- `rst_n`, input, 1 bit: synchronous, active-low reset.
- `word_in`, input, `WORD_W` bits: word to transmit. Sampled on accept.
- `start`, input, 1 bit: transfer request.
- `ready`, output, 1 bit: high when idle and able to accept.
- `done`, output, 1 bit: one-cycle pulse at frame end.
- `sclk`, output, 1 bit: serial clock to the receiver.
- `sdata`, output, 1 bit: serial data, MSB first.
- `en`, output, 1 bit: frame enable to the receiver.

## Operation

**Protocol.** The receiver samples `sdata` on each `sclk` rising edge while `en`=1. This block:
- changes `sdata` only while `sclk`=0;
- raises `en` a half-period before the first rising edge;
- drops `en` a half-period after the last falling edge.

**FSM states.** The FSM has states IDLE, LOW, HIGH and HOLD. A phase counter counts `HALF_DIV` cycles, and a bit counter runs from 0 to `WORD_W`-1.

- **IDLE**
  - Outputs: `sclk`=0, `sdata`=0, `en`=0, `ready`=1.
  - Accept occurs when `start`=1 and `ready`=1 on a clock edge. On accept, latch `word_in` into the shadow shift register, clear the bit counter, and go to LOW.
- **LOW**
  - Outputs: `en`=1, `sclk`=0, `sdata`=shadow[`WORD_W`-1].
  - After `HALF_DIV` cycles, go to HIGH.
- **HIGH**
  - Outputs: `sclk`=1, `sdata` held.
  - After `HALF_DIV` cycles:
    - if the bit counter is `WORD_W`-1, go to HOLD;
    - otherwise, shift the shadow register left by 1, increment the bit counter, and go to LOW.
- **HOLD**
  - Outputs: `sclk`=0, `en`=1, `sdata` held.
  - After `HALF_DIV` cycles, go to IDLE and assert `done` for exactly one cycle. `ready`=1 in that same cycle.

**Behaviour rules.**
- All serial outputs are registered, so they have no glitches.
- `start` while busy is ignored. It is not queued.
- `word_in` changes after accept do not affect the frame in flight.
- `start` held high continuously produces back-to-back frames: the next accept happens on the edge where `ready` is high, so there is one IDLE cycle with `en`=0 between frames.

## Timing

- Reset values: `ready`=1, `done`=0, `sclk`=0, `sdata`=0, `en`=0. The FSM is in IDLE and the counters are 0.
- Accept at edge N gives `en`=1 from cycle N+1.
- Frame length: `en` is high for exactly (2·`WORD_W`+1)·`HALF_DIV` cycles. This is 38 cycles for `WORD_W`=9, `HALF_DIV`=2.
- Edge count: exactly `WORD_W` `sclk` rising edges per frame. The first rising edge occurs `HALF_DIV` cycles after `en` rises.
- `done` coincides with the first cycle of `en`=0.
- `HALF_DIV`=1: `sclk` = `clk`/2. This case must still work.
- Reset mid-frame (`rst_n`=0 on any edge): all outputs return to their reset values on that edge and the frame is abandoned with no `done`. The receiver word is then undefined, and the source must resend.

## Configuration

- `DSM_SERIAL_LOADER_AUTO_EN` defined:
  - The block keeps a copy of the last transmitted word. The copy is reset to 0, with a "never sent" flag set.
  - In IDLE, if the flag is set or `word_in` differs from the copy, the block self-starts exactly as on `start`.
  - The copy updates on accept, and the flag clears on accept.
  - Explicit `start` still works.
- Not defined: transfers start only on `start`. There is no copy register and the flag logic is absent.

## Test plan

- `HALF_DIV`=2, `word_in`=9'h1A5, `start` pulse:
  - sdata at the rising edges is 1,1,0,1,0,0,1,0,1;
  - `en` is high for 38 cycles;
  - the receiver model holds 9'h1A5;
  - `done` is a single-cycle pulse.
- `start` pulsed again at frame midpoint with `word_in`=9'h0FF: ignored. The frame still delivers 9'h1A5, and a later `start` delivers 9'h0FF.
- `HALF_DIV`=1, word 9'h155: `sclk` toggles every `clk` cycle, 9 rising edges, and the receiver holds 9'h155.
- `rst_n` low at the 5th `sclk` high phase:
  - next edge: `en`=0, `sclk`=0, `ready`=1;
  - no `done`.
  
  A subsequent `start` with 9'h003 then delivers 9'h003.
- `start` held high, words 9'h001 then 9'h100: two frames separated by exactly 1 cycle of `en`=0, and the receiver sees 9'h001 then 9'h100.
- `DSM_SERIAL_LOADER_AUTO_EN` defined:
  - after reset, one frame of 9'h000 is sent with no `start`;
  - changing `word_in` to 9'h07A triggers one frame;
  - holding the value constant triggers no further frames.
